// File: rtl/watchdog_multi.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | watchdog_multi : N_CH heartbeat watchdogs sharing one force_reset pulse.    |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module watchdog_multi #(
  parameter int     N_CH      = 4,
  parameter int     CNT_W     = 32,
  parameter longint TIMEOUT   = 1000,
  parameter longint WARN      = 750,
  parameter longint WIN_MIN   = 0,
  parameter int     PULSE_LEN = 16,
  localparam int    FCH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_CH-1:0]  enable,
  input  logic [N_CH-1:0]  heartbeat,
  input  logic             clear_fault,
  output logic             force_reset,
  output logic [N_CH-1:0]  warning,
  output logic [N_CH-1:0]  timeout_flag,
  output logic [N_CH-1:0]  early_flag,
  output logic             fault_any,
  output logic [FCH_W-1:0] fault_ch
);

  localparam logic [1:0] ARMED = 2'd0;
  localparam logic [1:0] PULSE = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam int              PC_W    = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [PC_W-1:0] PC_LOAD = PC_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WARN_C  = CNT_W'(WARN);
  localparam logic [CNT_W-1:0] WIN_C   = CNT_W'(WIN_MIN);
  localparam logic             WIN_ON  = (WIN_MIN != 0);

  logic [1:0]       state;
  logic [PC_W-1:0]  pulse_cnt;
  logic [CNT_W-1:0] cnt [N_CH];
  logic [N_CH-1:0]  early_hit;
  logic [N_CH-1:0]  to_hit;
  logic [N_CH-1:0]  fault_hit;
  logic [FCH_W-1:0] first_ch;
  logic             armed;
  logic             do_clear;

  assign armed     = (state == ARMED);
  assign do_clear  = (state == HOLD) && clear_fault;
  assign fault_hit = early_hit | to_hit;

  // Fault detection is gated by ARMED, which is what freezes faults in PULSE/HOLD.
  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      assign early_hit[i] = armed & enable[i] & heartbeat[i] & WIN_ON & (cnt[i] < WIN_C);
      assign to_hit[i]    = armed & enable[i] & ~heartbeat[i] & (cnt[i] == TO_LAST);
      assign warning[i]   = enable[i] & (cnt[i] >= WARN_C) & ~timeout_flag[i];
    end
  endgenerate

  always_comb begin
    first_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (fault_hit[i]) first_ch = FCH_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (!rstn || do_clear) begin
        cnt[i] <= '0;
      end else if (armed) begin
        if (!enable[i]) begin
          cnt[i] <= '0;
        end else if (heartbeat[i]) begin
          if (!early_hit[i]) cnt[i] <= '0;
        end else if (!to_hit[i]) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= ARMED;
      pulse_cnt    <= '0;
      force_reset  <= 1'b0;
      timeout_flag <= '0;
      early_flag   <= '0;
      fault_any    <= 1'b0;
      fault_ch     <= '0;
    end else begin
      case (state)
        ARMED: begin
          if (|fault_hit) begin
            timeout_flag <= timeout_flag | to_hit;
            early_flag   <= early_flag | early_hit;
            fault_any    <= 1'b1;
            fault_ch     <= first_ch;
            force_reset  <= 1'b1;
            pulse_cnt    <= PC_LOAD;
            state        <= PULSE;
          end
        end
        PULSE: begin
          if (pulse_cnt == '0) begin
            force_reset <= 1'b0;
            state       <= HOLD;
          end else begin
            pulse_cnt <= pulse_cnt - PC_W'(1);
          end
        end
        HOLD: begin
          force_reset <= 1'b0;
          if (clear_fault) begin
            timeout_flag <= '0;
            early_flag   <= '0;
            fault_any    <= 1'b0;
            fault_ch     <= '0;
            state        <= ARMED;
          end
        end
        default: begin
          force_reset <= 1'b0;
          state       <= ARMED;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_watchdog_multi.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_watchdog_multi : directed bench, 2 channels, TIMEOUT=20 WARN=15 WIN=4.   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_watchdog_multi;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] enable;
  logic [1:0] heartbeat;
  logic       clear_fault;
  logic       force_reset;
  logic [1:0] warning;
  logic [1:0] timeout_flag;
  logic [1:0] early_flag;
  logic       fault_any;
  logic       fault_ch;

  int vectors = 0;
  int errors  = 0;

  localparam logic [1:0] S_ARMED = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd2;

  watchdog_multi #(
    .N_CH(2), .CNT_W(8), .TIMEOUT(20), .WARN(15), .WIN_MIN(4), .PULSE_LEN(3)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .heartbeat(heartbeat),
    .clear_fault(clear_fault), .force_reset(force_reset), .warning(warning),
    .timeout_flag(timeout_flag), .early_flag(early_flag),
    .fault_any(fault_any), .fault_ch(fault_ch)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_clear();
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic seen;
    // 1: reset with random inputs
    rstn = 1'b0;
    enable = 2'($urandom); heartbeat = 2'($urandom); clear_fault = 1'($urandom);
    tick();
    enable = 2'($urandom); heartbeat = 2'($urandom); clear_fault = 1'($urandom);
    tick();
    chk("rst_force", {31'd0, force_reset}, 32'd0);
    chk("rst_warn", {30'd0, warning}, 32'd0);
    chk("rst_tflag", {30'd0, timeout_flag}, 32'd0);
    chk("rst_eflag", {30'd0, early_flag}, 32'd0);
    chk("rst_any", {31'd0, fault_any}, 32'd0);
    chk("rst_ch", {31'd0, fault_ch}, 32'd0);
    chk("rst_state", {30'd0, dut.state}, {30'd0, S_ARMED});
    chk("rst_cnt0", {24'd0, dut.cnt[0]}, 32'd0);
    chk("rst_cnt1", {24'd0, dut.cnt[1]}, 32'd0);

    // 2: single-channel timeout
    rstn = 1'b1; enable = 2'b01; heartbeat = 2'b00; clear_fault = 1'b0;
    for (int k = 1; k <= 14; k++) tick();
    chk("t2_warn_e14", {30'd0, warning}, 32'd0);
    tick();
    chk("t2_warn_e15", {30'd0, warning}, 32'd1);
    for (int k = 16; k <= 19; k++) tick();
    chk("t2_force_e19", {31'd0, force_reset}, 32'd0);
    tick();
    chk("t2_force_e20", {31'd0, force_reset}, 32'd1);
    chk("t2_tflag", {30'd0, timeout_flag}, 32'd1);
    chk("t2_any", {31'd0, fault_any}, 32'd1);
    chk("t2_ch", {31'd0, fault_ch}, 32'd0);
    chk("t2_warn_masked", {30'd0, warning}, 32'd0);
    tick();
    chk("t2_pulse2", {31'd0, force_reset}, 32'd1);
    tick();
    chk("t2_pulse3", {31'd0, force_reset}, 32'd1);
    tick();
    chk("t2_pulse_end", {31'd0, force_reset}, 32'd0);
    chk("t2_hold", {30'd0, dut.state}, {30'd0, S_HOLD});
    chk("t2_hold_warn", {30'd0, warning}, 32'd0);
    tick();
    chk("t2_hold_force", {31'd0, force_reset}, 32'd0);
    chk("t2_hold_tflag", {30'd0, timeout_flag}, 32'd1);
    do_clear();
    chk("t2_clr_tflag", {30'd0, timeout_flag}, 32'd0);
    chk("t2_clr_any", {31'd0, fault_any}, 32'd0);
    chk("t2_clr_state", {30'd0, dut.state}, {30'd0, S_ARMED});

    // 3: both channels kicked every 10 cycles
    enable = 2'b11;
    seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      heartbeat = (c % 10 == 9) ? 2'b11 : 2'b00;
      tick();
      seen = seen | force_reset | (|warning) | (|timeout_flag) | (|early_flag) | fault_any;
    end
    heartbeat = 2'b00;
    chk("t3_quiet", {31'd0, seen}, 32'd0);

    // 4: ch1 kicked at count 10, then again two cycles later
    enable = 2'b10;
    for (int k = 0; k < 10; k++) tick();
    chk("t4_cnt1", {24'd0, dut.cnt[1]}, 32'd10);
    heartbeat = 2'b10; tick();
    chk("t4_legal_kick", {31'd0, force_reset}, 32'd0);
    heartbeat = 2'b00; tick();
    heartbeat = 2'b10; tick();
    heartbeat = 2'b00;
    chk("t4_force", {31'd0, force_reset}, 32'd1);
    chk("t4_eflag", {30'd0, early_flag}, 32'd2);
    chk("t4_ch", {31'd0, fault_ch}, 32'd1);
    chk("t4_tflag", {30'd0, timeout_flag}, 32'd0);
    tick(); tick();
    chk("t4_pulse3", {31'd0, force_reset}, 32'd1);
    tick();
    chk("t4_pulse_end", {31'd0, force_reset}, 32'd0);
    chk("t4_tflag_hold", {30'd0, timeout_flag}, 32'd0);
    enable = 2'b00;
    do_clear();

    // 5a: both channels time out on the same edge
    enable = 2'b11;
    for (int k = 1; k <= 19; k++) tick();
    chk("t5_force_e19", {31'd0, force_reset}, 32'd0);
    tick();
    chk("t5_force_e20", {31'd0, force_reset}, 32'd1);
    chk("t5_tflag", {30'd0, timeout_flag}, 32'd3);
    chk("t5_ch", {31'd0, fault_ch}, 32'd0);
    tick(); tick();
    chk("t5_pulse3", {31'd0, force_reset}, 32'd1);
    tick();
    chk("t5_pulse_end", {31'd0, force_reset}, 32'd0);
    enable = 2'b00;
    do_clear();

    // 5b: heartbeat on the timeout edge wins
    enable = 2'b01;
    for (int k = 1; k <= 19; k++) tick();
    heartbeat = 2'b01; tick();
    heartbeat = 2'b00;
    chk("t5b_force", {31'd0, force_reset}, 32'd0);
    chk("t5b_tflag", {30'd0, timeout_flag}, 32'd0);
    chk("t5b_cnt0", {24'd0, dut.cnt[0]}, 32'd0);

    // 6: clear ignored during pulse, honoured in hold, reset mid-pulse
    for (int k = 1; k <= 19; k++) tick();
    chk("t6_force_e19", {31'd0, force_reset}, 32'd0);
    tick();
    chk("t6_force_e20", {31'd0, force_reset}, 32'd1);
    clear_fault = 1'b1;
    tick();
    chk("t6_clr_pulse2", {31'd0, force_reset}, 32'd1);
    tick();
    chk("t6_clr_pulse3", {31'd0, force_reset}, 32'd1);
    chk("t6_clr_ign_flag", {30'd0, timeout_flag}, 32'd1);
    clear_fault = 1'b0;
    tick();
    chk("t6_pulse_end", {31'd0, force_reset}, 32'd0);
    chk("t6_hold_flag", {30'd0, timeout_flag}, 32'd1);
    do_clear();
    chk("t6_clr_flag", {30'd0, timeout_flag}, 32'd0);
    chk("t6_clr_any", {31'd0, fault_any}, 32'd0);
    for (int k = 1; k <= 19; k++) tick();
    chk("t6_rearm_e19", {31'd0, force_reset}, 32'd0);
    tick();
    chk("t6_rearm_e20", {31'd0, force_reset}, 32'd1);
    rstn = 1'b0;
    tick();
    chk("t6_rst_force", {31'd0, force_reset}, 32'd0);
    chk("t6_rst_flag", {30'd0, timeout_flag}, 32'd0);
    chk("t6_rst_any", {31'd0, fault_any}, 32'd0);
    chk("t6_rst_state", {30'd0, dut.state}, {30'd0, S_ARMED});
    rstn = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/watchdog_multi.md
Name: watchdog_multi

Overview:
- Parametrised multi-channel successor to the single-channel watchdog_timer.
- Each of N_CH channels has its own heartbeat, arm enable, warning threshold and optional early-kick window check.
- Any channel fault fires one shared force_reset pulse of programmable length. The block then holds in a latched fault state until software clears it.
- Sits between the control/status interface and the system reset generator.

Parameters:
- N_CH, 4, number of independent watchdog channels (1..16)
- CNT_W, 32, width of each channel counter
- TIMEOUT, 1000, cycles without heartbeat before timeout (2..2^CNT_W-1)
- WARN, 750, counter value at and above which warning asserts (1..TIMEOUT-1)
- WIN_MIN, 0, minimum counter value for a legal heartbeat; 0 disables the early-kick check (must be < WARN)
- PULSE_LEN, 16, force_reset pulse length in cycles (>=1)

Ports:
- clk, in, 1, system clock
- rstn, in, 1, synchronous active-low reset
- enable, in, N_CH, per-channel arm; 0 holds that channel idle
- heartbeat, in, N_CH, per-channel kick, sampled each cycle (level, one kick per high cycle)
- clear_fault, in, 1, clears latched fault state (honoured only in HOLD)
- force_reset, out, 1, registered reset request pulse
- warning, out, N_CH, channel counter >= WARN and no timeout on that channel
- timeout_flag, out, N_CH, sticky: channel timed out
- early_flag, out, N_CH, sticky: channel kicked before WIN_MIN
- fault_any, out, 1, OR of all sticky flags
- fault_ch, out, max(1,$clog2(N_CH)), index of the lowest channel that caused the pulse

Behaviour:
- Reset (rstn=0 at a clk edge):
  - all counters = 0; state = ARMED.
  - force_reset, warning, timeout_flag, early_flag, fault_any and fault_ch all go to 0.
  - Reset overrides everything, including mid-PULSE: force_reset is 0 after the first reset edge.
- Channel counter, updated only in ARMED:
  - enable[i]=0: counter = 0; no faults possible; warning[i] = 0.
  - enable[i]=1, heartbeat[i]=1, WIN_MIN>0 and counter < WIN_MIN: early fault; counter holds.
  - enable[i]=1, heartbeat[i]=1, otherwise: counter = 0.
  - enable[i]=1, heartbeat[i]=0, counter == TIMEOUT-1: timeout fault; counter holds at TIMEOUT-1.
  - enable[i]=1, heartbeat[i]=0, otherwise: counter +1.
  - Net effect: force_reset rises at the TIMEOUT-th enabled edge without a kick.
  - Heartbeat and timeout in the same cycle: the heartbeat wins (counter cleared, no fault).
- warning[i] is combinational from registers: enable[i] & (counter >= WARN) & ~timeout_flag[i].
- Global FSM, states ARMED / PULSE / HOLD:
  - ARMED, any fault this edge:
    - set the matching sticky flags; several channels in one cycle set all their flags;
    - fault_ch = lowest faulting index;
    - force_reset = 1; pulse counter = PULSE_LEN-1; go to PULSE.
  - PULSE:
    - force_reset stays 1 for exactly PULSE_LEN cycles, then 0; go to HOLD.
    - Channel counters are frozen, so no new faults are raised.
    - clear_fault is ignored.
  - HOLD:
    - force_reset = 0; counters frozen; flags hold.
    - clear_fault=1 clears all sticky flags, fault_ch and all counters; go to ARMED on the next edge.
- Re-arming:
  - A fault can only fire after a clear, so there is never more than one pulse per clear.
  - After a clear, a channel needs a full TIMEOUT cycles to time out again.
- fault_any is registered, and updates on the same edge as the flags.
- Widths: no counter wrap; the counter saturates at TIMEOUT-1. Compare with TIMEOUT and WARN cast to CNT_W.

Test Plan (N_CH=2, TIMEOUT=20, WARN=15, WIN_MIN=4, PULSE_LEN=3):
1. rstn=0 for 2 cycles, random inputs -> every output 0; state ARMED; counters 0.
2. enable=2'b01, no heartbeat ->
   - warning[0] high after 15 enabled edges;
   - force_reset, timeout_flag[0] and fault_any rise at edge 20; fault_ch=0;
   - force_reset is high exactly 3 cycles, then HOLD with warning[0]=0.
3. enable=2'b11, heartbeat on both every 10 cycles for 300 cycles -> no warning, no flags, force_reset never high.
4. ch1 kicked at counter=10, then kicked again 2 cycles later -> early_flag[1]=1; fault_ch=1; one 3-cycle pulse; timeout_flag stays 0.
5. Both channels enabled on the same edge, never kicked ->
   - timeout_flag=2'b11 on the same edge; fault_ch=0; a single 3-cycle pulse;
   - heartbeat and timeout landing in the same cycle on ch0 instead -> ch0 is not flagged.
6. Pulse control and re-arm:
   - clear_fault during PULSE -> ignored; pulse still 3 cycles.
   - clear_fault in HOLD -> flags 0 next cycle; the next timeout needs 20 more cycles.
   - rstn=0 in cycle 2 of a pulse -> force_reset 0 after that edge.
